block_to_raster: RTL and testbench

//  Converts a stream of 8x8 pixel blocks back into raster-scan RGB pixels.

---
 rtl/block_to_raster.sv | 204 ++++++++++++++++++++
 tb/tb_block_to_raster.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/block_to_raster.sv
// Reorders 8x8-block pixel streams into raster-scan lines using two stripe-sized
// ping-pong banks; drains through a 2-entry skid buffer onto a valid/ready port.
//
// state   | meaning
// ST_IDLE | waiting for bank rd_sel to be full
// ST_READ | issuing one RAM read per cycle, raster order over the stripe
module block_to_raster #(
    parameter int IMAGE_HIGH  = 720,
    parameter int IMAGE_WIDTH = 1280,
    parameter int AW          = 14
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [23:0] jpeg_rgb_data_in,
    input  logic        jpeg_rgb_data_en,
    input  logic        jpeg_rgb_data_last,
    output logic        jpeg_rgb_data_ready,
    output logic [23:0] data_out,
    output logic        data_out_valid,
    input  logic        data_out_ready,
    output logic        data_out_user,
    output logic        data_out_last,
    output logic        sync_err
);

    localparam int STRIPE = IMAGE_WIDTH * 8;
    localparam int XW     = ($clog2(IMAGE_WIDTH) > 3) ? $clog2(IMAGE_WIDTH) : 4;
    localparam int LW     = ($clog2(IMAGE_HIGH) > 0) ? $clog2(IMAGE_HIGH) : 1;
    localparam logic [AW-1:0] WR_LAST   = AW'(STRIPE - 1);
    localparam logic [XW-1:0] X_LAST    = XW'(IMAGE_WIDTH - 1);
    localparam logic [LW-1:0] LINE_LAST = LW'(IMAGE_HIGH - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_READ = 1'b1
    } state_t;

    // Both banks live in one array; the bank select is the address MSB.
    logic [23:0]   mem [2**(AW+1)];

    logic [AW-1:0] wr_cnt;
    logic          wr_sel;
    logic          wr_accept;
    logic          wr_end;
    logic          bank_set;
    logic [1:0]    bank_full;

    state_t        state;
    state_t        state_n;
    logic          rd_sel;
    logic          rd_issue;
    logic          rd_done;
    logic          room;
    logic [XW-1:0] rd_x;
    logic [2:0]    rd_y;
    logic [AW-1:0] rd_addr;
    logic [23:0]   ram_q;
    logic          ram_last;
    logic          rd_pending;

    logic [24:0]   buf_mem [2];
    logic          buf_wp;
    logic          buf_rp;
    logic [1:0]    buf_cnt;
    logic [2:0]    occ;
    logic          push;
    logic          pop;
    logic [24:0]   head;

    logic [LW-1:0] rd_line;
    logic          at_x0;

    // ---------------- write side ----------------
    assign jpeg_rgb_data_ready = !bank_full[wr_sel];
    assign wr_accept = jpeg_rgb_data_en & jpeg_rgb_data_ready;
    assign wr_end    = (wr_cnt == WR_LAST);
    assign bank_set  = wr_accept & wr_end;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            wr_cnt   <= '0;
            wr_sel   <= 1'b0;
            sync_err <= 1'b0;
        end else if (wr_accept) begin
            if (wr_end) begin
                wr_cnt <= '0;
                wr_sel <= ~wr_sel;
            end else if (jpeg_rgb_data_last) begin
                wr_cnt   <= '0;
                sync_err <= 1'b1;
            end else begin
                wr_cnt <= wr_cnt + AW'(1);
            end
        end
    end

    // Set and clear always target different banks; the clear is written last.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            bank_full <= '0;
        end else begin
            if (bank_set) bank_full[wr_sel] <= 1'b1;
            if (rd_done)  bank_full[rd_sel] <= 1'b0;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (wr_accept) mem[{wr_sel, wr_cnt}] <= jpeg_rgb_data_in;
        if (rd_issue)  ram_q <= mem[{rd_sel, rd_addr}];
    end

    // ---------------- read FSM ----------------
    assign rd_addr = AW'({rd_x[XW-1:3], rd_y, rd_x[2:0]});

    // Credit the pop happening this cycle so a steady drain runs at 1 pixel/clk.
    assign occ  = {1'b0, buf_cnt} + {2'b00, rd_pending};
    assign room = (occ < 3'd2) || (pop && (occ == 3'd2));

    always_comb begin
        state_n  = state;
        rd_issue = 1'b0;
        rd_done  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bank_full[rd_sel]) state_n = ST_READ;
            end
            ST_READ: begin
                if (room) begin
                    rd_issue = 1'b1;
                    if ((rd_x == X_LAST) && (rd_y == 3'd7)) begin
                        rd_done = 1'b1;
                        state_n = ST_IDLE;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state      <= ST_IDLE;
            rd_sel     <= 1'b0;
            rd_x       <= '0;
            rd_y       <= '0;
            rd_pending <= 1'b0;
            ram_last   <= 1'b0;
        end else begin
            state      <= state_n;
            rd_pending <= rd_issue;
            if (rd_done) rd_sel <= ~rd_sel;
            if (rd_issue) begin
                ram_last <= (rd_x == X_LAST);
                if (rd_x == X_LAST) begin
                    rd_x <= '0;
                    rd_y <= rd_y + 3'd1;
                end else begin
                    rd_x <= rd_x + XW'(1);
                end
            end
        end
    end

    // ---------------- output buffer ----------------
    assign push = rd_pending;
    assign pop  = data_out_valid & data_out_ready;
    assign head = buf_mem[buf_rp];

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            buf_wp  <= 1'b0;
            buf_rp  <= 1'b0;
            buf_cnt <= '0;
        end else begin
            if (push) buf_wp <= ~buf_wp;
            if (pop)  buf_rp <= ~buf_rp;
            buf_cnt <= buf_cnt + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge sys_clk) begin
        if (push) buf_mem[buf_wp] <= {ram_last, ram_q};
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            rd_line <= '0;
            at_x0   <= 1'b1;
        end else if (pop) begin
            if (head[24]) begin
                at_x0   <= 1'b1;
                rd_line <= (rd_line == LINE_LAST) ? '0 : rd_line + LW'(1);
            end else begin
                at_x0 <= 1'b0;
            end
        end
    end

    assign data_out_valid = (buf_cnt != 2'd0);
    assign data_out       = data_out_valid ? head[23:0] : 24'd0;
    assign data_out_last  = data_out_valid & head[24];
    assign data_out_user  = data_out_valid & at_x0 & (rd_line == '0);

endmodule

// File: tb/tb_block_to_raster.sv
// Directed bench for block_to_raster with a 16x16 frame: block-ordered input,
// raster-ordered output checked pixel by pixel against the raster index.
module tb_block_to_raster;

    localparam int W  = 16;
    localparam int H  = 16;
    localparam int AW = 7;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic [23:0] jpeg_rgb_data_in = '0;
    logic        jpeg_rgb_data_en = 1'b0;
    logic        jpeg_rgb_data_last = 1'b0;
    logic        jpeg_rgb_data_ready;
    logic [23:0] data_out;
    logic        data_out_valid;
    logic        data_out_ready = 1'b0;
    logic        data_out_user;
    logic        data_out_last;
    logic        sync_err;

    int checks  = 0;
    int errors  = 0;
    int in_cnt  = 0;
    int in_lim  = 0;
    int out_cnt = 0;
    bit chk_en  = 1'b1;

    block_to_raster #(.IMAGE_HIGH(H), .IMAGE_WIDTH(W), .AW(AW)) dut (
        .sys_clk            (sys_clk),
        .sys_rst            (sys_rst),
        .jpeg_rgb_data_in   (jpeg_rgb_data_in),
        .jpeg_rgb_data_en   (jpeg_rgb_data_en),
        .jpeg_rgb_data_last (jpeg_rgb_data_last),
        .jpeg_rgb_data_ready(jpeg_rgb_data_ready),
        .data_out           (data_out),
        .data_out_valid     (data_out_valid),
        .data_out_ready     (data_out_ready),
        .data_out_user      (data_out_user),
        .data_out_last      (data_out_last),
        .sync_err           (sync_err)
    );

    always #5 sys_clk = ~sys_clk;

    // Block-order input index n -> pixel value equal to its raster index in the frame sequence.
    function automatic logic [23:0] src_pix(input int n);
        int f, k, s, m, b, r, c;
        f = n / 256;
        k = n % 256;
        s = k / 128;
        m = k % 128;
        b = m / 64;
        r = (m % 64) / 8;
        c = m % 8;
        return 24'(f * 256 + (s * 8 + r) * 16 + b * 8 + c);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock window: drive, check any presented pixel, account transfers, advance.
    task automatic cycle(input bit en_ok, input bit rdy);
        jpeg_rgb_data_en   = en_ok && (in_cnt < in_lim);
        jpeg_rgb_data_in   = src_pix(in_cnt);
        jpeg_rgb_data_last = ((in_cnt % 256) == 255);
        data_out_ready     = rdy;
        #1;
        if (data_out_valid === 1'b1) begin
            if (chk_en) begin
                chk("pix_data", 32'(data_out), 32'(out_cnt));
                chk("pix_user", 32'(data_out_user), 32'((out_cnt % 256) == 0));
                chk("pix_last", 32'(data_out_last), 32'((out_cnt % 16) == 15));
            end
            if (rdy) out_cnt++;
        end
        if (jpeg_rgb_data_en && (jpeg_rgb_data_ready === 1'b1)) in_cnt++;
        @(posedge sys_clk);
        #1;
    endtask

    task automatic do_reset();
        sys_rst            = 1'b1;
        jpeg_rgb_data_en   = 1'b0;
        jpeg_rgb_data_last = 1'b0;
        data_out_ready     = 1'b0;
        @(posedge sys_clk);
        #1;
        chk("rst_valid", 32'(data_out_valid), 32'd0);
        chk("rst_ready", 32'(jpeg_rgb_data_ready), 32'd1);
        chk("rst_sync_err", 32'(sync_err), 32'd0);
        chk("rst_user", 32'(data_out_user), 32'd0);
        chk("rst_last", 32'(data_out_last), 32'd0);
        chk("rst_data", 32'(data_out), 32'd0);
        sys_rst = 1'b0;
        in_cnt  = 0;
        out_cnt = 0;
    endtask

    task automatic run(input string tag, input int lim, input int rmode, input int n_out,
                       input int max_cyc);
        int c;
        bit r;
        in_lim = lim;
        c = 0;
        while ((out_cnt < n_out || in_cnt < lim) && c < max_cyc) begin
            if (rmode == 1) r = 1'($urandom_range(0, 1));
            else            r = (rmode == 0);
            cycle(1'b1, r);
            c++;
        end
        chk({tag, "_out_count"}, 32'(out_cnt), 32'(n_out));
        chk({tag, "_in_count"}, 32'(in_cnt), 32'(lim));
    endtask

    initial begin
        int cyc, acc128, fv, rel, run_len, runs;

        do_reset();

        // 1: two stripes, sink always ready; also first-valid latency after stripe fills
        in_lim = 256;
        cyc = 0; acc128 = -1; fv = -1;
        while ((out_cnt < 256 || in_cnt < 256) && cyc < 2000) begin
            if (fv < 0 && data_out_valid === 1'b1) fv = cyc;
            cycle(1'b1, 1'b1);
            if (acc128 < 0 && in_cnt == 128) acc128 = cyc;
            cyc++;
        end
        chk("t1_out_count", 32'(out_cnt), 32'd256);
        chk("t1_latency_le4", 32'((fv > acc128) && (fv - acc128 <= 4)), 32'd1);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1);
        chk("t1_idle_valid", 32'(data_out_valid), 32'd0);
        chk("t1_sync_err", 32'(sync_err), 32'd0);

        // 2: same stimulus with random sink stalls
        do_reset();
        run("t2", 256, 1, 256, 5000);

        // 3: sink stalled, writer blocks after two stripes; release and time the reopen
        do_reset();
        in_lim = 512;
        for (int i = 0; i < 300; i++) cycle(1'b1, 1'b0);
        chk("t3_accepted", 32'(in_cnt), 32'd256);
        chk("t3_ready_low", 32'(jpeg_rgb_data_ready), 32'd0);
        chk("t3_no_xfer", 32'(out_cnt), 32'd0);
        // Reads 3..128 of bank 0 issue on release cycles 0..125; bank reopens on cycle 126.
        rel = 0;
        while (jpeg_rgb_data_ready !== 1'b1 && rel < 200) begin
            cycle(1'b1, 1'b1);
            rel++;
        end
        chk("t3_ready_rise", 32'(rel), 32'd126);
        run("t3", 512, 0, 512, 3000);

        // 4: three back-to-back frames; valid runs of exactly one stripe
        do_reset();
        in_lim = 768;
        cyc = 0; run_len = 0; runs = 0;
        while (!(out_cnt == 768 && in_cnt == 768 && data_out_valid !== 1'b1) && cyc < 4000) begin
            cycle(1'b1, 1'b1);
            if (data_out_valid === 1'b1) begin
                run_len++;
            end else if (run_len > 0) begin
                chk("t4_run_len", 32'(run_len), 32'd128);
                runs++;
                run_len = 0;
            end
            cyc++;
        end
        chk("t4_out_count", 32'(out_cnt), 32'd768);
        chk("t4_runs", 32'(runs), 32'd6);

        // 5: frame last at wr_cnt=5 discards the partial stripe and sets sync_err
        do_reset();
        for (int i = 0; i < 6; i++) begin
            jpeg_rgb_data_en   = 1'b1;
            jpeg_rgb_data_in   = 24'hABC000 | 24'(i);
            jpeg_rgb_data_last = (i == 5);
            data_out_ready     = 1'b1;
            #1;
            chk("t5_wr_ready", 32'(jpeg_rgb_data_ready), 32'd1);
            @(posedge sys_clk);
            #1;
        end
        jpeg_rgb_data_en   = 1'b0;
        jpeg_rgb_data_last = 1'b0;
        chk("t5_sync_err_set", 32'(sync_err), 32'd1);
        in_lim = 0;
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1);
        chk("t5_no_output", 32'(data_out_valid), 32'd0);
        in_cnt  = 0;
        out_cnt = 0;
        run("t5", 128, 0, 128, 1000);
        chk("t5_sync_err_sticky", 32'(sync_err), 32'd1);

        // 6: reset mid-stripe while output is flowing, then a clean frame
        chk_en = 1'b0;
        in_cnt = 0;
        out_cnt = 0;
        in_lim = 256;
        cyc = 0;
        while (out_cnt < 40 && cyc < 500) begin
            cycle(1'b1, 1'b1);
            cyc++;
        end
        chk("t6_pre_out", 32'(out_cnt), 32'd40);
        do_reset();
        chk_en = 1'b1;
        run("t6", 256, 0, 256, 2000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
